ace_snoop_ctrl: RTL

- Sequences one ACE snoop transaction at a time between the interconnect snoop channels (AC in; CR and CD out) and the private data cache's snoop port.
- Decodes AC snoop type, performs a tag lookup, commands the resulting state action, returns the CR response, then streams a dirty/shared line as CD beats.
- Sits beside the cache controller; its ports map onto the snoop_req_t / snoop_resp_t fields.

---
 rtl/ace_snoop_pkg.sv | 39 +++
 rtl/ace_snoop_decode.sv | 55 +++++
 rtl/ace_snoop_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ace_snoop_pkg.sv
// rtl/ace_snoop_pkg.sv - ACE snoop encodings, cache action type and snoop FSM states
package ace_snoop_pkg;

  localparam logic [3:0] ACSNOOP_READ_ONCE     = 4'b0000;
  localparam logic [3:0] ACSNOOP_READ_SHARED   = 4'b0001;
  localparam logic [3:0] ACSNOOP_READ_CLEAN    = 4'b0010;
  localparam logic [3:0] ACSNOOP_READ_NSD      = 4'b0011;
  localparam logic [3:0] ACSNOOP_READ_UNIQUE   = 4'b0111;
  localparam logic [3:0] ACSNOOP_CLEAN_SHARED  = 4'b1000;
  localparam logic [3:0] ACSNOOP_CLEAN_INVALID = 4'b1001;
  localparam logic [3:0] ACSNOOP_MAKE_INVALID  = 4'b1101;

  localparam int unsigned CR_DATA_TRANSFER = 0;
  localparam int unsigned CR_ERROR         = 1;
  localparam int unsigned CR_PASS_DIRTY    = 2;
  localparam int unsigned CR_IS_SHARED     = 3;
  localparam int unsigned CR_WAS_UNIQUE    = 4;

  typedef enum logic [1:0] {
    ACT_NONE       = 2'd0,
    ACT_DOWNGRADE  = 2'd1,
    ACT_CLEAN      = 2'd2,
    ACT_INVALIDATE = 2'd3
  } act_op_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LKP, S_WAIT, S_ACT, S_CR, S_CD
  } snoop_state_e;

  function automatic logic snoop_supported(input logic [3:0] snoop);
    case (snoop)
      ACSNOOP_READ_ONCE, ACSNOOP_READ_SHARED, ACSNOOP_READ_CLEAN, ACSNOOP_READ_NSD,
      ACSNOOP_READ_UNIQUE, ACSNOOP_CLEAN_SHARED, ACSNOOP_CLEAN_INVALID,
      ACSNOOP_MAKE_INVALID: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ace_snoop_decode.sv
// rtl/ace_snoop_decode.sv - maps snoop type and line state to CR response, cache action and read
module ace_snoop_decode
  import ace_snoop_pkg::*;
(
  input  logic [3:0] snoop_i,
  input  logic       hit_i,
  input  logic       dirty_i,
  input  logic       shared_i,
  output logic [4:0] cr_resp_o,
  output act_op_t    act_op_o,
  output logic       read_o
);

  logic dt, is_shared, pass_dirty;

  always_comb begin
    dt         = 1'b0;
    is_shared  = 1'b0;
    pass_dirty = 1'b0;
    act_op_o   = ACT_NONE;
    case (snoop_i)
      ACSNOOP_READ_ONCE, ACSNOOP_READ_CLEAN: begin
        dt = 1'b1; is_shared = 1'b1;
      end
      ACSNOOP_READ_SHARED, ACSNOOP_READ_NSD: begin
        dt = 1'b1; is_shared = 1'b1; pass_dirty = dirty_i; act_op_o = ACT_DOWNGRADE;
      end
      ACSNOOP_READ_UNIQUE: begin
        dt = 1'b1; pass_dirty = dirty_i; act_op_o = ACT_INVALIDATE;
      end
      ACSNOOP_CLEAN_SHARED: begin
        is_shared = 1'b1;
        if (dirty_i) begin
          dt = 1'b1; pass_dirty = 1'b1; act_op_o = ACT_CLEAN;
        end
      end
      ACSNOOP_CLEAN_INVALID: begin
        dt = dirty_i; pass_dirty = dirty_i; act_op_o = ACT_INVALIDATE;
      end
      ACSNOOP_MAKE_INVALID: act_op_o = ACT_INVALIDATE;
      default: ;
    endcase
    // A miss owns nothing: no data, no state change, empty response
    if (!hit_i) begin
      dt = 1'b0; is_shared = 1'b0; pass_dirty = 1'b0; act_op_o = ACT_NONE;
    end
    cr_resp_o                   = '0;
    cr_resp_o[CR_WAS_UNIQUE]    = hit_i & ~shared_i;
    cr_resp_o[CR_IS_SHARED]     = is_shared;
    cr_resp_o[CR_PASS_DIRTY]    = pass_dirty;
    cr_resp_o[CR_DATA_TRANSFER] = dt;
    read_o                      = dt;
  end

endmodule

// File: rtl/ace_snoop_ctrl.sv
// rtl/ace_snoop_ctrl.sv - sequences one ACE snoop: AC accept, tag lookup, cache action, CR, CD burst
module ace_snoop_ctrl
  import ace_snoop_pkg::*;
#(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned LineWidth = 512
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ac_valid_i,
  output logic                 ac_ready_o,
  input  logic [AddrWidth-1:0] ac_addr_i,
  input  logic [3:0]           ac_snoop_i,
  output logic                 cr_valid_o,
  input  logic                 cr_ready_i,
  output logic [4:0]           cr_resp_o,
  output logic                 cd_valid_o,
  input  logic                 cd_ready_i,
  output logic [DataWidth-1:0] cd_data_o,
  output logic                 cd_last_o,
  output logic                 lkp_valid_o,
  input  logic                 lkp_ready_i,
  output logic [AddrWidth-1:0] lkp_addr_o,
  input  logic                 lkp_rsp_valid_i,
  input  logic                 lkp_hit_i,
  input  logic                 lkp_dirty_i,
  input  logic                 lkp_shared_i,
  output logic                 act_valid_o,
  input  logic                 act_ready_i,
  output logic [1:0]           act_op_o,
  output logic                 act_read_o,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  input  logic [DataWidth-1:0] data_i
);

  localparam int unsigned BeatsPerLine = LineWidth / DataWidth;
  localparam int unsigned OffBits      = $clog2(LineWidth / 8);
  localparam int unsigned CntW         = (BeatsPerLine > 1) ? $clog2(BeatsPerLine) : 1;
  localparam logic [CntW-1:0]      LastBeat = CntW'(BeatsPerLine - 1);
  localparam logic [AddrWidth-1:0] LineMask = {AddrWidth{1'b1}} << OffBits;

  snoop_state_e         state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [3:0]           snoop_q, snoop_d;
  logic [4:0]           resp_q, resp_d;
  act_op_t              op_q, op_d;
  logic                 read_q, read_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [4:0]           dec_resp;
  act_op_t              dec_op;
  logic                 dec_read;
  logic                 cd_fire;

  ace_snoop_decode u_decode (
    .snoop_i   (snoop_q),
    .hit_i     (lkp_hit_i),
    .dirty_i   (lkp_dirty_i),
    .shared_i  (lkp_shared_i),
    .cr_resp_o (dec_resp),
    .act_op_o  (dec_op),
    .read_o    (dec_read)
  );

  assign cd_fire = (state_q == S_CD) && data_valid_i && cd_ready_i;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    snoop_d = snoop_q;
    resp_d  = resp_q;
    op_d    = op_q;
    read_d  = read_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (ac_valid_i) begin
        addr_d  = ac_addr_i & LineMask;
        snoop_d = ac_snoop_i;
        if (snoop_supported(ac_snoop_i)) begin
          state_d = S_LKP;
        end else begin
          resp_d  = '0;
          op_d    = ACT_NONE;
          read_d  = 1'b0;
          state_d = S_CR;
        end
      end
      S_LKP: if (lkp_ready_i) state_d = S_WAIT;
      // No state change and nothing to read: the action handshake is skipped
      S_WAIT: if (lkp_rsp_valid_i) begin
        resp_d  = dec_resp;
        op_d    = dec_op;
        read_d  = dec_read;
        state_d = (dec_op == ACT_NONE && !dec_read) ? S_CR : S_ACT;
      end
      S_ACT: if (act_ready_i) state_d = S_CR;
      S_CR: if (cr_ready_i) state_d = resp_q[CR_DATA_TRANSFER] ? S_CD : S_IDLE;
      S_CD: if (cd_fire) begin
        if (cnt_q == LastBeat) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
    addr_q  <= addr_d;
    snoop_q <= snoop_d;
    resp_q  <= resp_d;
    op_q    <= op_d;
    read_q  <= read_d;
  end

  // Handshake outputs are forced low while reset is asserted
  assign ac_ready_o   = ~rst_i & (state_q == S_IDLE);
  assign lkp_valid_o  = ~rst_i & (state_q == S_LKP);
  assign act_valid_o  = ~rst_i & (state_q == S_ACT);
  assign act_read_o   = act_valid_o & read_q;
  assign cr_valid_o   = ~rst_i & (state_q == S_CR);
  assign cd_valid_o   = ~rst_i & (state_q == S_CD) & data_valid_i;
  assign data_ready_o = ~rst_i & (state_q == S_CD) & cd_ready_i;
  assign cd_last_o    = ~rst_i & (state_q == S_CD) & (cnt_q == LastBeat);
  assign cd_data_o    = data_i;
  assign lkp_addr_o   = addr_q;
  assign cr_resp_o    = resp_q;
  assign act_op_o     = op_q;

endmodule
